// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array complex MAC cell: mode encodings
// and a constant-foldable ceil(log2) helper for sizing pointers and counters.
package sa_pkg;

  typedef enum logic [1:0] {
    SA_MODE_MAC    = 2'd0,
    SA_MODE_ELEM   = 2'd1,
    SA_MODE_CMAC   = 2'd2,
    SA_MODE_BYPASS = 2'd3
  } sa_mode_e;

  function automatic int sa_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sa_wfifo.sv
// Weight FIFO: single push per cycle, pops a (real, imag) pair in one cycle.
// Zero-latency pop data; push_rdy drops only when full; a pair pop needs >=2 entries.
module sa_wfifo
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WBUF_DEPTH = 16,
  localparam int CW = sa_clog2(WBUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_vld,
  output logic                  push_rdy,
  input  logic [DATA_WIDTH-1:0] push_dat,
  input  logic                  pop_req,
  output logic                  pop_fire,
  output logic [DATA_WIDTH-1:0] pop_re_dat,
  output logic [DATA_WIDTH-1:0] pop_im_dat,
  output logic [CW-1:0]         count
);

  localparam int AW = sa_clog2(WBUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [WBUF_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_fire;

  assign push_rdy   = (count != CW'(WBUF_DEPTH));
  assign push_fire  = push_vld & push_rdy;
  assign pop_fire   = pop_req & (count >= CW'(2));
  assign pop_re_dat = mem[rd_ptr];
  assign pop_im_dat = mem[rd_ptr + AW'(1)];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + AW'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + AW'(2);
      count <= count + CW'(push_fire) - (pop_fire ? CW'(2) : CW'(0));
    end
  end

  // Write slot never aliases the pair being read: a pop needs count>=2 and a push needs count<DEPTH.
  always_ff @(posedge clk) begin
    if (push_fire && !rst) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/sa_cmac_cell.sv
// Systolic complex MAC cell: east forward after 1 cycle, south result after 2 cycles.
// No backpressure on the sample path; weight pushes stall via w_in_ready when the FIFO is full.
module sa_cmac_cell
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 0,
  parameter int WBUF_DEPTH = 16,
  localparam int CW = sa_clog2(WBUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] left_re,
  input  logic [DATA_WIDTH-1:0] left_im,
  input  logic [DATA_WIDTH-1:0] up_re,
  input  logic [DATA_WIDTH-1:0] up_im,
  input  logic [DATA_WIDTH-1:0] w_in,
  input  logic                  w_in_valid,
  output logic                  w_in_ready,
  input  logic                  w_load,
  output logic [DATA_WIDTH-1:0] right_re,
  output logic [DATA_WIDTH-1:0] right_im,
  output logic                  right_valid,
  output logic [DATA_WIDTH-1:0] down_re,
  output logic [DATA_WIDTH-1:0] down_im,
  output logic                  down_valid,
  output logic [CW-1:0]         w_count,
  output logic                  w_load_err
);

  localparam int PW = 2 * DATA_WIDTH;
  typedef logic signed [PW-1:0] prod_t;

  function automatic prod_t sext(input logic [DATA_WIDTH-1:0] v);
    return prod_t'($signed(v));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] scale(input prod_t p);
    return DATA_WIDTH'(p >>> FRAC_BITS);
  endfunction

  logic [DATA_WIDTH-1:0] w_re, w_im, fifo_re, fifo_im;
  logic                  load_fire;

  sa_wfifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .WBUF_DEPTH (WBUF_DEPTH)
  ) u_wfifo (
    .clk        (clk),
    .rst        (rst),
    .push_vld   (w_in_valid),
    .push_rdy   (w_in_ready),
    .push_dat   (w_in),
    .pop_req    (w_load),
    .pop_fire   (load_fire),
    .pop_re_dat (fifo_re),
    .pop_im_dat (fifo_im),
    .count      (w_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      w_re       <= '0;
      w_im       <= '0;
      w_load_err <= 1'b0;
    end else begin
      if (load_fire) begin
        w_re <= fifo_re;
        w_im <= fifo_im;
      end
      w_load_err <= w_load & ~load_fire;
    end
  end

  // East forward and pipeline valids
  logic s1_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      right_re    <= '0;
      right_im    <= '0;
      right_valid <= 1'b0;
      s1_vld      <= 1'b0;
    end else begin
      right_valid <= in_valid;
      s1_vld      <= in_valid;
      if (in_valid) begin
        right_re <= left_re;
        right_im <= left_im;
      end
    end
  end

  // Stage 1: products against the weight currently held, so a same-cycle load is not seen.
  sa_mode_e              s1_mode;
  logic [DATA_WIDTH-1:0] s1_up_re, s1_up_im;
  prod_t                 p_rr, p_ii, p_ri, p_ir;

  always_ff @(posedge clk) begin
    if (in_valid) begin
      s1_mode  <= sa_mode_e'(mode);
      s1_up_re <= up_re;
      s1_up_im <= up_im;
      p_rr     <= sext(left_re) * sext(w_re);
      p_ii     <= sext(left_im) * sext(w_im);
      p_ri     <= sext(left_re) * sext(w_im);
      p_ir     <= sext(left_im) * sext(w_re);
    end
  end

  // Stage 2: combine scaled products; all sums wrap at DATA_WIDTH.
  logic [DATA_WIDTH-1:0] t_rr, t_ii, t_ri, t_ir, sum_re, sum_im;

  always_comb begin
    t_rr   = scale(p_rr);
    t_ii   = scale(p_ii);
    t_ri   = scale(p_ri);
    t_ir   = scale(p_ir);
    sum_re = s1_up_re;
    sum_im = s1_up_im;
    case (s1_mode)
      SA_MODE_MAC: begin
        sum_re = s1_up_re + t_rr - t_ii;
        sum_im = s1_up_im + t_ri + t_ir;
      end
      SA_MODE_ELEM: begin
        sum_re = t_rr - t_ii;
        sum_im = t_ri + t_ir;
      end
      SA_MODE_CMAC: begin
        sum_re = s1_up_re + t_rr + t_ii;
        sum_im = s1_up_im + t_ir - t_ri;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      down_re    <= '0;
      down_im    <= '0;
      down_valid <= 1'b0;
    end else begin
      down_valid <= s1_vld;
      if (s1_vld) begin
        down_re <= sum_re;
        down_im <= sum_im;
      end
    end
  end

endmodule

// File: tb/tb_sa_cmac_cell.sv
// Self-checking bench for sa_cmac_cell: default build plus 8-bit and fixed-point builds.
module tb_sa_cmac_cell;
  import sa_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  mode;
  logic        in_valid, w_in_valid, w_in_ready, w_load, w_load_err;
  logic [31:0] left_re, left_im, up_re, up_im, w_in;
  logic [31:0] right_re, right_im, down_re, down_im;
  logic        right_valid, down_valid;
  logic [4:0]  w_count;

  logic [1:0]  b_mode;
  logic        b_in_valid, b_w_in_valid, b_w_in_ready, b_w_load, b_w_load_err;
  logic [7:0]  b_left_re, b_left_im, b_up_re, b_up_im, b_w_in;
  logic [7:0]  b_right_re, b_right_im, b_down_re, b_down_im;
  logic        b_right_valid, b_down_valid;
  logic [4:0]  b_w_count;

  logic [1:0]  f_mode;
  logic        f_in_valid, f_w_in_valid, f_w_in_ready, f_w_load, f_w_load_err;
  logic [31:0] f_left_re, f_left_im, f_up_re, f_up_im, f_w_in;
  logic [31:0] f_right_re, f_right_im, f_down_re, f_down_im;
  logic        f_right_valid, f_down_valid;
  logic [4:0]  f_w_count;

  sa_cmac_cell dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid),
    .left_re(left_re), .left_im(left_im), .up_re(up_re), .up_im(up_im),
    .w_in(w_in), .w_in_valid(w_in_valid), .w_in_ready(w_in_ready), .w_load(w_load),
    .right_re(right_re), .right_im(right_im), .right_valid(right_valid),
    .down_re(down_re), .down_im(down_im), .down_valid(down_valid),
    .w_count(w_count), .w_load_err(w_load_err)
  );

  sa_cmac_cell #(.DATA_WIDTH(8), .FRAC_BITS(0), .WBUF_DEPTH(16)) dut8 (
    .clk(clk), .rst(rst), .mode(b_mode), .in_valid(b_in_valid),
    .left_re(b_left_re), .left_im(b_left_im), .up_re(b_up_re), .up_im(b_up_im),
    .w_in(b_w_in), .w_in_valid(b_w_in_valid), .w_in_ready(b_w_in_ready), .w_load(b_w_load),
    .right_re(b_right_re), .right_im(b_right_im), .right_valid(b_right_valid),
    .down_re(b_down_re), .down_im(b_down_im), .down_valid(b_down_valid),
    .w_count(b_w_count), .w_load_err(b_w_load_err)
  );

  sa_cmac_cell #(.DATA_WIDTH(32), .FRAC_BITS(4), .WBUF_DEPTH(16)) dutf (
    .clk(clk), .rst(rst), .mode(f_mode), .in_valid(f_in_valid),
    .left_re(f_left_re), .left_im(f_left_im), .up_re(f_up_re), .up_im(f_up_im),
    .w_in(f_w_in), .w_in_valid(f_w_in_valid), .w_in_ready(f_w_in_ready), .w_load(f_w_load),
    .right_re(f_right_re), .right_im(f_right_im), .right_valid(f_right_valid),
    .down_re(f_down_re), .down_im(f_down_im), .down_valid(f_down_valid),
    .w_count(f_w_count), .w_load_err(f_w_load_err)
  );

  typedef struct packed { logic [31:0] re; logic [31:0] im; } cplx_t;
  cplx_t       q[$];
  logic [15:0] q8[$];
  logic [63:0] qf[$];
  int checks = 0;
  int errors = 0;

  // Reference: full complex product with the (optionally conjugated) weight, wrapped to 32 bits.
  function automatic cplx_t model(input logic [1:0] m, input logic [31:0] lr, li, ur, ui, wr, wi);
    longint a_r, a_i, b_r, b_i, pre, pim;
    cplx_t r;
    a_r = longint'($signed(lr)); a_i = longint'($signed(li));
    b_r = longint'($signed(wr)); b_i = longint'($signed(wi));
    if (m == 2'd2) b_i = -b_i;
    pre = a_r * b_r - a_i * b_i;
    pim = a_r * b_i + a_i * b_r;
    case (m)
      2'd1:    r = '{re: pre[31:0], im: pim[31:0]};
      2'd3:    r = '{re: ur, im: ui};
      default: r = '{re: ur + pre[31:0], im: ui + pim[31:0]};
    endcase
    return r;
  endfunction

  task automatic push_w(input logic [31:0] v);
    w_in = v; w_in_valid = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0;
  endtask

  task automatic do_load;
    w_load = 1'b1;
    @(negedge clk);
    w_load = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] lr, li, ur, ui, input cplx_t e);
    mode = m; left_re = lr; left_im = li; up_re = ur; up_im = ui; in_valid = 1'b1;
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; mode = 2'd0; in_valid = 0; left_re = 0; left_im = 0; up_re = 0; up_im = 0;
    w_in = 0; w_in_valid = 0; w_load = 0;
    b_mode = 0; b_in_valid = 0; b_left_re = 0; b_left_im = 0; b_up_re = 0; b_up_im = 0;
    b_w_in = 0; b_w_in_valid = 0; b_w_load = 0;
    f_mode = 0; f_in_valid = 0; f_left_re = 0; f_left_im = 0; f_up_re = 0; f_up_im = 0;
    f_w_in = 0; f_w_in_valid = 0; f_w_load = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if (w_count !== 5'd0) begin errors++; $display("FAIL reset_w_count: got %0d expected 0", w_count); end
    checks++;
    if (w_in_ready !== 1'b1) begin errors++; $display("FAIL reset_w_in_ready: got %b expected 1", w_in_ready); end
    checks++;
    if ({down_valid, right_valid, w_load_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {down_valid, right_valid, w_load_err});
    end
    checks++;
    if ({down_re, down_im, right_re, right_im} !== 128'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {down_re, down_im, right_re, right_im});
    end
  endtask

  task automatic test_mac;
    cplx_t e;
    push_w(32'd3); push_w(32'd4); do_load;
    checks++;
    if (w_count !== 5'd0) begin errors++; $display("FAIL mac_w_count: got %0d expected 0", w_count); end
    send(2'd0, 32'd1, 32'd2, 32'd10, 32'd20, '{re: 32'd5, im: 32'd30});
    checks++;
    if ({right_valid, right_re, right_im} !== {1'b1, 32'd1, 32'd2}) begin
      errors++; $display("FAIL mac_right: got v=%b (%0d,%0d) expected v=1 (1,2)", right_valid, right_re, right_im);
    end
    checks++;
    if (down_valid !== 1'b0) begin errors++; $display("FAIL mac_latency_early: got down_valid=%b expected 0", down_valid); end
    @(negedge clk);
    checks++;
    if (down_valid !== 1'b1 || q.size() == 0) begin
      errors++; $display("FAIL mac_latency: got down_valid=%b expected 1", down_valid);
    end else begin
      e = q.pop_front();
      if ({down_re, down_im} !== e) begin
        errors++; $display("FAIL mac_down: got (%0d,%0d) expected (%0d,%0d)",
                           $signed(down_re), $signed(down_im), $signed(e.re), $signed(e.im));
      end
    end
    checks++;
    if (right_valid !== 1'b0) begin errors++; $display("FAIL mac_right_idle: got %b expected 0", right_valid); end
    @(negedge clk);
    checks++;
    if ({down_valid, down_re, down_im} !== {1'b0, 32'd5, 32'd30}) begin
      errors++; $display("FAIL mac_hold: got v=%b (%0d,%0d) expected v=0 (5,30)", down_valid, down_re, down_im);
    end
    q.delete();
  endtask

  task automatic test_back_to_back;
    logic [1:0] modes [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
    cplx_t exps [4] = '{'{32'd21, 32'd22}, '{-32'sd5, 32'd10}, '{32'd10, 32'd20}, '{32'd5, 32'd30}};
    cplx_t e;
    for (int i = 0; i < 8; i++) begin
      if (down_valid) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_unexpected: got extra result expected none"); end
        else begin
          e = q.pop_front();
          if ({down_re, down_im} !== e) begin
            errors++; $display("FAIL b2b_down: got (%0d,%0d) expected (%0d,%0d)",
                               $signed(down_re), $signed(down_im), $signed(e.re), $signed(e.im));
          end
        end
      end
      if (i < 4) send(modes[i], 32'd1, 32'd2, 32'd10, 32'd20, exps[i]);
      else @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL b2b_missing: got %0d pending expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_random_stream;
    logic [31:0] wr, wi, lr, li, ur, ui;
    logic [1:0] m;
    cplx_t e;
    wr = $urandom; wi = $urandom;
    push_w(wr); push_w(wi); do_load;
    for (int i = 0; i < 40; i++) begin
      if (down_valid) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL rand_unexpected: got extra result expected none"); end
        else begin
          e = q.pop_front();
          if ({down_re, down_im} !== e) begin
            errors++; $display("FAIL rand_down: got (%h,%h) expected (%h,%h)", down_re, down_im, e.re, e.im);
          end
        end
      end
      if (i < 36 && $urandom_range(0, 3) != 0) begin
        lr = $urandom; li = $urandom; ur = $urandom; ui = $urandom; m = 2'($urandom_range(0, 3));
        send(m, lr, li, ur, ui, model(m, lr, li, ur, ui, wr, wi));
      end else @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rand_missing: got %0d pending expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_fifo;
    cplx_t e;
    w_in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin w_in = 32'(100 + i); @(negedge clk); end
    w_in_valid = 1'b0;
    checks++;
    if ({w_count, w_in_ready} !== {5'd16, 1'b0}) begin
      errors++; $display("FAIL fifo_full: got count=%0d ready=%b expected 16 0", w_count, w_in_ready);
    end
    do_load;
    checks++;
    if ({w_count, w_in_ready} !== {5'd14, 1'b1}) begin
      errors++; $display("FAIL fifo_after_load: got count=%0d ready=%b expected 14 1", w_count, w_in_ready);
    end
    w_in = 32'd200; w_in_valid = 1'b1; w_load = 1'b1;
    @(negedge clk);
    w_in_valid = 1'b0; w_load = 1'b0;
    checks++;
    if (w_count !== 5'd13) begin errors++; $display("FAIL fifo_push_pop: got %0d expected 13", w_count); end
    repeat (6) do_load;
    checks++;
    if (w_count !== 5'd1) begin errors++; $display("FAIL fifo_drain: got %0d expected 1", w_count); end
    w_load = 1'b1;
    @(negedge clk);
    w_load = 1'b0;
    checks++;
    if ({w_load_err, w_count} !== {1'b1, 5'd1}) begin
      errors++; $display("FAIL load_err: got err=%b count=%0d expected 1 1", w_load_err, w_count);
    end
    @(negedge clk);
    checks++;
    if (w_load_err !== 1'b0) begin errors++; $display("FAIL load_err_pulse: got %b expected 0", w_load_err); end
    push_w(32'd201);
    // Load and sample in the same cycle: the sample sees the old weight, the next one the new.
    w_load = 1'b1;
    send(2'd1, 32'd1, 32'd0, 32'd99, 32'd99, '{32'd114, 32'd115});
    w_load = 1'b0;
    send(2'd1, 32'd1, 32'd0, 32'd99, 32'd99, '{32'd200, 32'd201});
    for (int i = 0; i < 5 && q.size() > 0; i++) begin
      if (down_valid) begin
        e = q.pop_front();
        checks++;
        if ({down_re, down_im} !== e) begin
          errors++; $display("FAIL fifo_weights: got (%0d,%0d) expected (%0d,%0d)", down_re, down_im, e.re, e.im);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL fifo_missing: got %0d pending expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_reset_inflight;
    int seen;
    push_w(32'd7); push_w(32'd8);
    mode = 2'd0; left_re = 32'd9; left_im = 32'd9; up_re = 32'd9; up_im = 32'd9; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (down_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL rst_inflight_valid: got %0d results expected 0", seen); end
    checks++;
    if ({w_count, down_re, down_im, right_re} !== 101'd0) begin
      errors++; $display("FAIL rst_inflight_state: got count=%0d down=(%0d,%0d) right=%0d expected all 0",
                         w_count, down_re, down_im, right_re);
    end
    send(2'd1, 32'd1, 32'd0, 32'd5, 32'd5, '{32'd0, 32'd0});
    @(negedge clk);
    checks++;
    if ({down_valid, down_re, down_im} !== {1'b1, 64'd0}) begin
      errors++; $display("FAIL rst_weights: got v=%b (%0d,%0d) expected v=1 (0,0)", down_valid, down_re, down_im);
    end
    q.delete();
  endtask

  task automatic test_wrap;
    logic [15:0] e8;
    logic [63:0] ef;
    b_w_in = 8'd127; f_w_in = 32'd16; b_w_in_valid = 1'b1; f_w_in_valid = 1'b1;
    @(negedge clk);
    b_w_in = 8'd0; f_w_in = 32'd0;
    @(negedge clk);
    b_w_in_valid = 1'b0; f_w_in_valid = 1'b0; b_w_load = 1'b1; f_w_load = 1'b1;
    @(negedge clk);
    b_w_load = 1'b0; f_w_load = 1'b0;
    b_mode = 2'd1; b_left_re = 8'd2; b_left_im = 8'd0; b_up_re = 8'd50; b_up_im = 8'd0; b_in_valid = 1'b1;
    f_mode = 2'd1; f_left_re = 32'd5; f_left_im = 32'd0; f_up_re = 32'd0; f_up_im = 32'd0; f_in_valid = 1'b1;
    q8.push_back({8'hFE, 8'h00}); qf.push_back({32'd5, 32'd0});
    @(negedge clk);
    b_mode = 2'd2; b_up_re = 8'd5;
    f_left_re = 32'hFFFF_FFFB;
    q8.push_back({8'd3, 8'd0}); qf.push_back({32'hFFFF_FFFB, 32'd0});
    @(negedge clk);
    b_in_valid = 1'b0; f_in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (b_down_valid && q8.size() > 0) begin
        e8 = q8.pop_front();
        checks++;
        if ({b_down_re, b_down_im} !== e8) begin
          errors++; $display("FAIL wrap8: got (%0d,%0d) expected (%0d,%0d)",
                             $signed(b_down_re), $signed(b_down_im), $signed(e8[15:8]), $signed(e8[7:0]));
        end
      end
      if (f_down_valid && qf.size() > 0) begin
        ef = qf.pop_front();
        checks++;
        if ({f_down_re, f_down_im} !== ef) begin
          errors++; $display("FAIL frac4: got (%0d,%0d) expected (%0d,%0d)",
                             $signed(f_down_re), $signed(f_down_im), $signed(ef[63:32]), $signed(ef[31:0]));
        end
      end
      @(negedge clk);
    end
    checks++;
    if (q8.size() + qf.size() != 0) begin
      errors++; $display("FAIL wrap_missing: got %0d pending expected 0", q8.size() + qf.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mac();
    test_back_to_back();
    test_random_stream();
    test_fifo();
    test_reset_inflight();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_cmac_cell.md
SA_CMAC_CELL -- requirements
Module: sa_cmac_cell

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, signed two's-complement width of each real/imag component.
REQ-002 SHALL have parameter FRAC_BITS, default 0, fixed-point fraction bits; legal range 0..DATA_WIDTH-1.
REQ-003 SHALL have parameter WBUF_DEPTH, default 16, weight FIFO entries; power of 2, >=2.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port mode  in  2  0=MAC, 1=ELEM, 2=CMAC (conjugate weight), 3=BYPASS.
REQ-007 SHALL have ports in_valid (in, 1), left_re/left_im (in, DATA_WIDTH): west sample.
REQ-008 SHALL have ports up_re/up_im  in  DATA_WIDTH  north partial sum, sampled with in_valid.
REQ-009 SHALL have ports w_in (in, DATA_WIDTH), w_in_valid (in, 1), w_in_ready (out, 1): weight push handshake.
REQ-010 SHALL have port w_load  in  1  pulse: pop one complex weight from FIFO into weight register.
REQ-011 SHALL have ports right_re/right_im (out, DATA_WIDTH), right_valid (out, 1): east forward.
REQ-012 SHALL have ports down_re/down_im (out, DATA_WIDTH), down_valid (out, 1): south result.
REQ-013 SHALL have ports w_count (out, clog2(WBUF_DEPTH+1)) FIFO occupancy, w_load_err (out, 1) pulse.

Function
REQ-014 Weight FIFO SHALL accept w_in when w_in_valid && w_in_ready; w_in_ready = (w_count != WBUF_DEPTH).
REQ-015 Entries SHALL be consumed in pairs: first popped = real, second = imag; pointers wrap modulo WBUF_DEPTH.
REQ-016 w_load with w_count>=2 SHALL pop both entries in one cycle and update w_re/w_im on the next edge.
REQ-017 w_load with w_count<2 SHALL leave FIFO and weights unchanged and pulse w_load_err high for exactly 1 cycle.
REQ-018 Simultaneous accepted push and w_load SHALL both take effect; w_count changes by +1-2.
REQ-019 A sample with in_valid in the same cycle as w_load SHALL use the pre-load weight.
REQ-020 right_* SHALL equal left_* registered once; right_valid = in_valid delayed 1 cycle.
REQ-021 Datapath SHALL be 2 stages: stage 1 registers 4 full-width products; stage 2 combines; down_valid = in_valid delayed 2 cycles.
REQ-022 mode, up_* and in_valid SHALL travel with the sample; mode changes never corrupt in-flight samples.
REQ-023 MAC: down = up + left*w; ELEM: down = left*w (up ignored); CMAC: down = up + left*conj(w); BYPASS: down = up.
REQ-024 Each product SHALL be 2*DATA_WIDTH signed, arithmetic-shifted right by FRAC_BITS, truncated to low DATA_WIDTH bits.
REQ-025 All additions/subtractions SHALL wrap modulo 2^DATA_WIDTH; no saturation, no overflow flag.
REQ-026 With in_valid low, down_*/right_* SHALL hold previous values and valids SHALL be low.

Reset
REQ-027 rst SHALL clear w_count, FIFO pointers, w_re, w_im, all pipeline valids, right_*, down_*, w_load_err to 0.
REQ-028 rst SHALL dominate all inputs in the same cycle; in-flight samples SHALL be discarded (no down_valid after reset).
REQ-029 w_in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-030 Shared package sa_pkg SHALL hold mode encodings (SA_MODE_MAC/ELEM/CMAC/BYPASS) and the clog2 helper.
REQ-031 Weight FIFO SHALL be a sub-module sa_wfifo (parameters DATA_WIDTH, WBUF_DEPTH; single push, dual pop).
REQ-032 FIFO storage need not be reset; only pointers and count are reset.

Verification (DATA_WIDTH=32, FRAC_BITS=0 unless stated)
REQ-033 Push 3,4; w_load; next cycle left=(1,2), up=(10,20), mode 0 -> 2 cycles later down=(5,30), down_valid=1.
REQ-034 Same weights, mode 2, left=(1,2), up=(10,20) -> down=(21,22); mode 1 -> down=(-5,10).
REQ-035 Push 17 words with w_in_valid held -> 16 accepted, w_in_ready=0, w_count=16; w_load -> w_count=14, w_in_ready=1.
REQ-036 One entry in FIFO, w_load -> w_load_err 1-cycle pulse, w_count stays 1, weights unchanged.
REQ-037 in_valid at cycle N, rst at N+1 -> down_valid stays 0, w_count=0, down_*=0.
REQ-038 DATA_WIDTH=8, w=(127,0), left=(2,0), mode 1 -> down=(-2,0) (wrap); FRAC_BITS=4, w=(16,0), left=(5,0) -> down=(5,0).
